// File: rtl/spr_scoreboard_param_pkg.sv
// Shared constants and packed-port helpers for the SPR dependency scoreboard.
`ifndef SPR_SCOREBOARD_PARAM_PKG_SV
`define SPR_SCOREBOARD_PARAM_PKG_SV

`define SB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package spr_scoreboard_param_pkg;
  localparam int SPR_VCC     = 0;
  localparam int SPR_SCC     = 1;
  localparam int SPR_EXEC    = 2;
  localparam int SPR_M0      = 3;
  localparam int NUM_SPR_DEF = 4;

  // Width needed to hold a count of 0..n simultaneous events.
  function automatic int cnt_in_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

`endif

// File: rtl/spr_scoreboard_param_if.sv
// Decode/issue/retire/flush request bundle and ready/full/error status of the scoreboard.
interface spr_scoreboard_param_if
  import spr_scoreboard_param_pkg::*;
#(
  parameter int WF_PER_CU    = 40,
  parameter int WF_ID_LENGTH = 6,
  parameter int NUM_SPR      = NUM_SPR_DEF,
  parameter int NUM_ISSUE    = 2,
  parameter int NUM_RETIRE   = 2
);
  logic                               decode_valid;
  logic [WF_ID_LENGTH-1:0]            decode_wfid;
  logic [NUM_SPR-1:0]                 decode_spr_rd;
  logic [NUM_SPR-1:0]                 decode_spr_wr;
  logic [NUM_ISSUE-1:0]               issue_valid;
  logic [NUM_ISSUE*WF_ID_LENGTH-1:0]  issue_wfid;
  logic [NUM_ISSUE*NUM_SPR-1:0]       issue_spr_wr;
  logic [NUM_RETIRE-1:0]              retire_valid;
  logic [NUM_RETIRE*WF_ID_LENGTH-1:0] retire_wfid;
  logic [NUM_RETIRE*NUM_SPR-1:0]      retire_spr_wr;
  logic                               flush_valid;
  logic [WF_ID_LENGTH-1:0]            flush_wfid;
  logic [WF_PER_CU-1:0]               ready_arry_spr;
  logic [WF_PER_CU-1:0]               cnt_full;
  logic                               err_overflow;
  logic                               err_underflow;

  modport master (
    output decode_valid, decode_wfid, decode_spr_rd, decode_spr_wr,
           issue_valid, issue_wfid, issue_spr_wr,
           retire_valid, retire_wfid, retire_spr_wr,
           flush_valid, flush_wfid,
    input  ready_arry_spr, cnt_full, err_overflow, err_underflow
  );

  modport slave (
    input  decode_valid, decode_wfid, decode_spr_rd, decode_spr_wr,
           issue_valid, issue_wfid, issue_spr_wr,
           retire_valid, retire_wfid, retire_spr_wr,
           flush_valid, flush_wfid,
    output ready_arry_spr, cnt_full, err_overflow, err_underflow
  );
endinterface

// File: rtl/spr_scoreboard_param_cell.sv
// One (wavefront, SPR) slot: saturating outstanding-writer counter plus registered ready bit.
module spr_scoreboard_cell #(
  parameter int CNT_WIDTH = 2,
  parameter int INC_W     = 2,
  parameter int DEC_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc,
  input  logic [DEC_W-1:0] dec,
  input  logic             flush,
  input  logic             decode_hit,
  input  logic             depends,
  output logic             ready,
  output logic             full,
  output logic             ovf,
  output logic             unf
);
  localparam int                   SW      = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [SW-1:0]        sum;

  // Two guard bits: the top one is the sign, anything else above CNT_WIDTH means past max.
  always_comb begin
    sum     = {2'b00, cnt_q} + SW'(inc) - SW'(dec);
    cnt_d   = sum[CNT_WIDTH-1:0];
    ovf     = 1'b0;
    unf     = 1'b0;
    ready_d = ready_q;
    if (flush) begin
      cnt_d = '0;
    end else if (sum[SW-1]) begin
      cnt_d = '0;
      unf   = 1'b1;
    end else if (|sum[SW-2:CNT_WIDTH]) begin
      cnt_d = CNT_MAX;
      ovf   = 1'b1;
    end
    if (flush)
      ready_d = 1'b1;
    else if (decode_hit)
      ready_d = !(depends && (cnt_d != '0));
    else
      ready_d = ready_q | (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign full  = (cnt_q == CNT_MAX);
endmodule

// File: rtl/spr_scoreboard_param.sv
// Per-wavefront SPR dependency scoreboard: port matching, per-slot cells, reductions, sticky errors.
module spr_scoreboard_param
  import spr_scoreboard_param_pkg::*;
#(
  parameter int WF_PER_CU    = 40,
  parameter int WF_ID_LENGTH = 6,
  parameter int NUM_SPR      = NUM_SPR_DEF,
  parameter int NUM_ISSUE    = 2,
  parameter int NUM_RETIRE   = 2,
  parameter int CNT_WIDTH    = 2
) (
  input logic                 clk,
  input logic                 rst,
  spr_scoreboard_param_if.slave sb
);
  localparam int INC_W = cnt_in_width(NUM_ISSUE);
  localparam int DEC_W = cnt_in_width(NUM_RETIRE);

  logic [WF_PER_CU*NUM_SPR-1:0] ready_bits, full_bits, ovf_bits, unf_bits;
  logic [WF_PER_CU-1:0]         ready_wf, full_wf;
  logic                         err_ovf_q, err_unf_q;

  for (genvar w = 0; w < WF_PER_CU; w++) begin : g_wf
    logic decode_hit, flush_hit;
    assign decode_hit = sb.decode_valid && (sb.decode_wfid == WF_ID_LENGTH'(w));
    assign flush_hit  = sb.flush_valid  && (sb.flush_wfid  == WF_ID_LENGTH'(w));

    for (genvar s = 0; s < NUM_SPR; s++) begin : g_spr
      logic [INC_W-1:0] inc;
      logic [DEC_W-1:0] dec;

      always_comb begin
        inc = '0;
        for (int p = 0; p < NUM_ISSUE; p++)
          if (sb.issue_valid[p] && sb.issue_spr_wr[p*NUM_SPR+s] &&
              (`SB_SLICE(sb.issue_wfid, p, WF_ID_LENGTH) == WF_ID_LENGTH'(w)))
            inc = inc + INC_W'(1);
      end

      always_comb begin
        dec = '0;
        for (int p = 0; p < NUM_RETIRE; p++)
          if (sb.retire_valid[p] && sb.retire_spr_wr[p*NUM_SPR+s] &&
              (`SB_SLICE(sb.retire_wfid, p, WF_ID_LENGTH) == WF_ID_LENGTH'(w)))
            dec = dec + DEC_W'(1);
      end

      spr_scoreboard_cell #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_W     (INC_W),
        .DEC_W     (DEC_W)
      ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .dec        (dec),
        .flush      (flush_hit),
        .decode_hit (decode_hit),
        .depends    (sb.decode_spr_rd[s] | sb.decode_spr_wr[s]),
        .ready      (ready_bits[w*NUM_SPR+s]),
        .full       (full_bits[w*NUM_SPR+s]),
        .ovf        (ovf_bits[w*NUM_SPR+s]),
        .unf        (unf_bits[w*NUM_SPR+s])
      );
    end

    assign ready_wf[w] = &ready_bits[w*NUM_SPR +: NUM_SPR];
    assign full_wf[w]  = |full_bits[w*NUM_SPR +: NUM_SPR];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | (|ovf_bits);
      err_unf_q <= err_unf_q | (|unf_bits);
    end
  end

  assign sb.ready_arry_spr = ready_wf;
  assign sb.cnt_full       = full_wf;
  assign sb.err_overflow   = err_ovf_q;
  assign sb.err_underflow  = err_unf_q;
endmodule

// File: tb/tb_spr_scoreboard_param.sv
// Directed and randomized bench for spr_scoreboard_param against an integer reference model.
module tb_spr_scoreboard_param;
  import spr_scoreboard_param_pkg::*;

  localparam int WF   = 40;
  localparam int WL   = 6;
  localparam int NS   = 4;
  localparam int NI   = 2;
  localparam int NR   = 2;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  localparam logic [NS-1:0] M_VCC  = NS'(1 << SPR_VCC);
  localparam logic [NS-1:0] M_SCC  = NS'(1 << SPR_SCC);
  localparam logic [NS-1:0] M_EXEC = NS'(1 << SPR_EXEC);
  localparam logic [NS-1:0] M_M0   = NS'(1 << SPR_M0);

  logic clk;
  logic rst;

  spr_scoreboard_param_if #(
    .WF_PER_CU(WF), .WF_ID_LENGTH(WL), .NUM_SPR(NS), .NUM_ISSUE(NI), .NUM_RETIRE(NR)
  ) sb_if ();

  spr_scoreboard_param #(
    .WF_PER_CU(WF), .WF_ID_LENGTH(WL), .NUM_SPR(NS), .NUM_ISSUE(NI), .NUM_RETIRE(NR),
    .CNT_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain integer counters per (wf, spr), updated on each rising edge.
  int m_cnt [WF][NS];
  bit m_rdy [WF][NS];
  bit m_ovf, m_unf;
  int mi, md, mn;
  bit mr, mhit, mdep, mflush;

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WF; w++)
        for (int s = 0; s < NS; s++) begin
          m_cnt[w][s] = 0;
          m_rdy[w][s] = 1'b1;
        end
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      for (int w = 0; w < WF; w++)
        for (int s = 0; s < NS; s++) begin
          mi = 0;
          md = 0;
          for (int p = 0; p < NI; p++)
            if (sb_if.issue_valid[p] && sb_if.issue_spr_wr[p*NS+s] &&
                int'(sb_if.issue_wfid[p*WL +: WL]) == w) mi++;
          for (int p = 0; p < NR; p++)
            if (sb_if.retire_valid[p] && sb_if.retire_spr_wr[p*NS+s] &&
                int'(sb_if.retire_wfid[p*WL +: WL]) == w) md++;
          mflush = sb_if.flush_valid && (int'(sb_if.flush_wfid) == w);
          if (mflush) mn = 0;
          else begin
            mn = m_cnt[w][s] + mi - md;
            if (mn > MAXC) begin mn = MAXC; m_ovf = 1'b1; end
            if (mn < 0)    begin mn = 0;    m_unf = 1'b1; end
          end
          mhit = sb_if.decode_valid && (int'(sb_if.decode_wfid) == w);
          mdep = sb_if.decode_spr_rd[s] | sb_if.decode_spr_wr[s];
          if (mflush)    mr = 1'b1;
          else if (mhit) mr = !(mdep && mn != 0);
          else           mr = m_rdy[w][s] | (mn == 0);
          m_cnt[w][s] = mn;
          m_rdy[w][s] = mr;
        end
    end
  end

  logic [WF-1:0] exp_rdy, exp_full;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int w = 0; w < WF; w++) begin
        exp_rdy[w]  = 1'b1;
        exp_full[w] = 1'b0;
        for (int s = 0; s < NS; s++) begin
          exp_rdy[w]  = exp_rdy[w] & m_rdy[w][s];
          exp_full[w] = exp_full[w] | (m_cnt[w][s] == MAXC);
        end
      end
      check64("cyc_ready", 64'(sb_if.ready_arry_spr), 64'(exp_rdy));
      check64("cyc_full",  64'(sb_if.cnt_full),       64'(exp_full));
      check1 ("cyc_ovf",   sb_if.err_overflow,  m_ovf);
      check1 ("cyc_unf",   sb_if.err_underflow, m_unf);
    end
  end

  task automatic idle();
    sb_if.decode_valid  = 1'b0;
    sb_if.decode_wfid   = '0;
    sb_if.decode_spr_rd = '0;
    sb_if.decode_spr_wr = '0;
    sb_if.issue_valid   = '0;
    sb_if.issue_wfid    = '0;
    sb_if.issue_spr_wr  = '0;
    sb_if.retire_valid  = '0;
    sb_if.retire_wfid   = '0;
    sb_if.retire_spr_wr = '0;
    sb_if.flush_valid   = 1'b0;
    sb_if.flush_wfid    = '0;
  endtask

  task automatic set_issue(input int p, input int wf, input logic [NS-1:0] m);
    sb_if.issue_valid[p]           = 1'b1;
    sb_if.issue_wfid[p*WL +: WL]   = WL'(wf);
    sb_if.issue_spr_wr[p*NS +: NS] = m;
  endtask

  task automatic set_retire(input int p, input int wf, input logic [NS-1:0] m);
    sb_if.retire_valid[p]           = 1'b1;
    sb_if.retire_wfid[p*WL +: WL]   = WL'(wf);
    sb_if.retire_spr_wr[p*NS +: NS] = m;
  endtask

  task automatic set_decode(input int wf, input logic [NS-1:0] rd, input logic [NS-1:0] wr);
    sb_if.decode_valid  = 1'b1;
    sb_if.decode_wfid   = WL'(wf);
    sb_if.decode_spr_rd = rd;
    sb_if.decode_spr_wr = wr;
  endtask

  function automatic int pick_wf();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(40, 63));
    return int'($urandom_range(0, 5));
  endfunction

  task automatic rand_inputs();
    sb_if.decode_valid  = 1'($urandom_range(0, 1));
    sb_if.decode_wfid   = WL'(pick_wf());
    sb_if.decode_spr_rd = NS'($urandom & $urandom);
    sb_if.decode_spr_wr = NS'($urandom & $urandom);
    for (int p = 0; p < NI; p++) begin
      sb_if.issue_valid[p]           = 1'($urandom_range(0, 1));
      sb_if.issue_wfid[p*WL +: WL]   = WL'(pick_wf());
      sb_if.issue_spr_wr[p*NS +: NS] = NS'($urandom & $urandom);
    end
    for (int p = 0; p < NR; p++) begin
      sb_if.retire_valid[p]           = 1'($urandom_range(0, 1));
      sb_if.retire_wfid[p*WL +: WL]   = WL'(pick_wf());
      sb_if.retire_spr_wr[p*NS +: NS] = NS'($urandom & $urandom);
    end
    sb_if.flush_valid = ($urandom_range(0, 15) == 0);
    sb_if.flush_wfid  = WL'(pick_wf());
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    chk_en = 1'b1;
    check64("rst_ready", 64'(sb_if.ready_arry_spr), 64'hFF_FFFF_FFFF);
    check64("rst_full",  64'(sb_if.cnt_full),       64'h0);
    check1 ("rst_ovf",   sb_if.err_overflow,  1'b0);
    check1 ("rst_unf",   sb_if.err_underflow, 1'b0);
    rst = 1'b0;

    // two outstanding VCC writers on wf 5
    idle(); set_issue(0, 5, M_VCC); set_issue(1, 5, M_VCC); tick();
    check1("tw_issue", sb_if.ready_arry_spr[5], 1'b1);
    idle(); set_decode(5, M_VCC, '0); tick();
    check1("tw_decode", sb_if.ready_arry_spr[5], 1'b0);
    idle(); set_retire(0, 5, M_VCC); tick();
    check1("tw_retire1", sb_if.ready_arry_spr[5], 1'b0);
    idle(); set_retire(1, 5, M_VCC); tick();
    check1("tw_retire2", sb_if.ready_arry_spr[5], 1'b1);

    // decode and retire of the last writer in the same cycle
    idle(); set_issue(0, 3, M_SCC); tick();
    check1("sc_issue", sb_if.ready_arry_spr[3], 1'b1);
    idle(); set_decode(3, M_SCC, '0); set_retire(1, 3, M_SCC); tick();
    check1("sc_same", sb_if.ready_arry_spr[3], 1'b1);
    idle(); tick();
    check1("sc_after", sb_if.ready_arry_spr[3], 1'b1);

    // saturation of EXEC on wf 9
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(0, 9, M_EXEC); tick();
      check1("ov_full_ramp", sb_if.cnt_full[9], (i == 2));
    end
    check1("ov_no_err_yet", sb_if.err_overflow, 1'b0);
    idle(); set_issue(1, 9, M_EXEC); set_decode(9, M_EXEC, '0); tick();
    check1("ov_err", sb_if.err_overflow, 1'b1);
    check1("ov_full_held", sb_if.cnt_full[9], 1'b1);
    check1("ov_not_ready", sb_if.ready_arry_spr[9], 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(); set_retire(0, 9, M_EXEC); tick();
      check1("ov_drain_full", sb_if.cnt_full[9], 1'b0);
      check1("ov_drain_ready", sb_if.ready_arry_spr[9], (i == 2));
    end
    check1("ov_no_unf", sb_if.err_underflow, 1'b0);

    // flush wf 7 with a colliding retire
    idle(); set_issue(0, 7, M_M0); set_issue(1, 7, M_M0); tick();
    idle(); set_decode(7, '0, M_M0); tick();
    check1("fl_not_ready", sb_if.ready_arry_spr[7], 1'b0);
    idle(); sb_if.flush_valid = 1'b1; sb_if.flush_wfid = WL'(7); set_retire(0, 7, M_M0); tick();
    check1("fl_ready", sb_if.ready_arry_spr[7], 1'b1);
    check1("fl_no_unf", sb_if.err_underflow, 1'b0);
    idle(); set_retire(1, 7, M_M0); tick();
    check1("fl_late_unf", sb_if.err_underflow, 1'b1);

    // wf 2 decode without dependency, wf 4 activity alongside
    idle(); set_issue(0, 2, M_VCC); tick();
    idle(); set_decode(2, M_VCC, '0); tick();
    check1("in_dep", sb_if.ready_arry_spr[2], 1'b0);
    idle(); set_decode(2, '0, '0); tick();
    check1("in_nodep", sb_if.ready_arry_spr[2], 1'b1);
    idle(); set_issue(0, 4, M_VCC); set_decode(4, M_VCC, '0); tick();
    check1("in_wf2_kept", sb_if.ready_arry_spr[2], 1'b1);
    check1("in_wf4_busy", sb_if.ready_arry_spr[4], 1'b0);

    // out-of-range wavefront ids must not disturb anything
    idle(); set_issue(0, 45, M_VCC); set_retire(1, 50, M_SCC); tick();

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
